// File: rtl/adc_scan_scheduler_pkg.sv
// adc_scan_scheduler_pkg
//   Shared definitions for the ADC scan scheduler: FSM state encoding and
//   the requester-index width helper.
package adc_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_scan_scheduler_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: first set request at or after ptr,
//   wrapping modulo NREQ. The pointer register lives in the parent.
// Ports:
//   req   [NREQ]  request vector
//   ptr   [ID_W]  search start index
//   grant [NREQ]  one-hot winner (all zero if no request)
//   idx   [ID_W]  winner index
//   any           at least one request set
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic            found;
  logic [ID_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = ID_W'((int'(ptr) + k) % NREQ);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        idx        = pos;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Shares one SPI ADC engine between NREQ requesters. Round-robin picks a
//   request, pulses spi_start, waits for spi_data_valid (or a timeout) and
//   returns the tagged result as a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_chan         per-requester request level and channel
//   req_grant                  one-hot accept pulse
//   spi_start/spi_chan         engine start pulse and held channel
//   spi_data_valid/spi_data    engine result strobe and data
//   rsp_valid/rsp_id/rsp_chan/rsp_data/rsp_timeout  result, held until next
//   busy                       high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | no job; move to GRANT when any request is present
// GRANT  | arbitrate, issue grant + spi_start (or back to IDLE if withdrawn)
// WAIT   | count cycles until data_valid or TIMEOUT
// RESP   | rsp_valid pulse cycle; back to IDLE
module adc_scan_scheduler
  import adc_scan_scheduler_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int CH_W    = 3,
  parameter  int DATA_W  = 12,
  parameter  int TIMEOUT = 1023,
  localparam int ID_W    = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*CH_W-1:0] req_chan,
  output logic [NREQ-1:0]      req_grant,
  output logic                 spi_start,
  output logic [CH_W-1:0]      spi_chan,
  input  logic                 spi_data_valid,
  input  logic [DATA_W-1:0]    spi_data,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [CH_W-1:0]      rsp_chan,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_timeout,
  output logic                 busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic [CH_W-1:0] arb_chan;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    arb_chan = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == ID_W'(i)) arb_chan = req_chan[i*CH_W +: CH_W];
    end
  end

  // rsp_id/rsp_chan are copied from the in-flight job only when the result
  // is issued, so all rsp_* fields stay coherent until the next RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      cnt         <= '0;
      req_grant   <= '0;
      spi_start   <= 1'b0;
      spi_chan    <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_chan    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_grant <= '0;
      spi_start <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            state <= ST_GRANT;
            busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (arb_any) begin
            req_grant <= arb_grant;
            spi_start <= 1'b1;
            spi_chan  <= arb_chan;
            cur_id    <= arb_idx;
            ptr       <= (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
            cnt       <= '0;
            state     <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Data has priority over a timeout landing on the same cycle.
          if (spi_data_valid) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_chan    <= spi_chan;
            rsp_data    <= spi_data;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_chan    <= spi_chan;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler
//   Directed, table-driven bench for adc_scan_scheduler (NREQ=4, CH_W=3,
//   DATA_W=12, TIMEOUT=1023). Requester channels: 0->5, 1->2, 2->7, 3->1.
module tb_adc_scan_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_chan;
  logic [3:0]  req_grant;
  logic        spi_start;
  logic [2:0]  spi_chan;
  logic        spi_data_valid;
  logic [11:0] spi_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_chan;
  logic [11:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  adc_scan_scheduler #(.NREQ(4), .CH_W(3), .DATA_W(12), .TIMEOUT(1023)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_chan       (req_chan),
    .req_grant      (req_grant),
    .spi_start      (spi_start),
    .spi_chan       (spi_chan),
    .spi_data_valid (spi_data_valid),
    .spi_data       (spi_data),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_chan       (rsp_chan),
    .rsp_data       (rsp_data),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_rsp   = 0;

  always @(negedge clk) begin
    if (spi_start) n_start++;
    if (rsp_valid) n_rsp++;
  end

  typedef struct {
    logic [3:0]  mask;
    bit          hold;
    int          exp_id;
    int          lat;
    logic [11:0] data;
    bit          send;
    int          exp_delay;
    bit          exp_to;
    logic [11:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int chan_of(input int id);
    case (id)
      0: return 5;
      1: return 2;
      2: return 7;
      default: return 1;
    endcase
  endfunction

  // One job from IDLE: request, expect grant 2 cycles later, answer after
  // lat cycles (lat=0: data_valid in the grant-pulse cycle), check response.
  task automatic run_job(input logic [3:0] mask, input bit hold, input int exp_id,
                         input int lat, input logic [11:0] data, input bit send,
                         input int exp_delay, input bit exp_to, input logic [11:0] exp_data);
    int  w;
    int  d;
    int  extra;
    bit  got;
    req_valid = mask;
    got = 1'b0;
    w = 0;
    while (!got && w < 10) begin
      tick();
      w++;
      if (req_grant != 4'b0) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) begin
      req_valid = 4'b0;
      return;
    end
    chk("grant_latency", w, 2);
    chk("grant_onehot", 32'(req_grant), 32'(1 << exp_id));
    chk("spi_start", 32'(spi_start), 32'd1);
    chk("spi_chan", 32'(spi_chan), chan_of(exp_id));
    chk("busy_job", 32'(busy), 32'd1);
    if (!hold) req_valid = 4'b0;
    got = 1'b0;
    d = 0;
    extra = 0;
    while (!got && d < 1100) begin
      spi_data_valid = send && (d == lat);
      spi_data = data;
      tick();
      d++;
      spi_data_valid = 1'b0;
      if (rsp_valid) got = 1'b1;
      else if (spi_start || req_grant != 4'b0) extra++;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("rsp_delay", d, exp_delay);
    chk("rsp_id", 32'(rsp_id), exp_id);
    chk("rsp_chan", 32'(rsp_chan), chan_of(exp_id));
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    chk("spi_chan_held", 32'(spi_chan), chan_of(exp_id));
    chk("no_extra_start", extra, 0);
    tick();
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("rsp_hold", 32'(rsp_data), 32'(exp_data));
  endtask

  initial begin
    int cnt;
    int s0;
    int r0;

    vecs[0]  = '{4'b0001, 1'b0, 0,   40, 12'hABC, 1'b1,   41, 1'b0, 12'hABC};
    vecs[1]  = '{4'b0001, 1'b0, 0,    3, 12'h123, 1'b1,    4, 1'b0, 12'h123};
    vecs[2]  = '{4'b1010, 1'b0, 1,    5, 12'h456, 1'b1,    6, 1'b0, 12'h456};
    vecs[3]  = '{4'b1010, 1'b0, 3,    7, 12'h789, 1'b1,    8, 1'b0, 12'h789};
    vecs[4]  = '{4'b0110, 1'b0, 1,    0, 12'hFFF, 1'b1,    1, 1'b0, 12'hFFF};
    vecs[5]  = '{4'b1111, 1'b0, 2,    2, 12'h000, 1'b1,    3, 1'b0, 12'h000};
    vecs[6]  = '{4'b0101, 1'b0, 0,   10, 12'h5A5, 1'b1,   11, 1'b0, 12'h5A5};
    vecs[7]  = '{4'b0100, 1'b0, 2,    0, 12'hEEE, 1'b0, 1024, 1'b1, 12'h000};
    vecs[8]  = '{4'b1000, 1'b0, 3,    1, 12'h321, 1'b1,    2, 1'b0, 12'h321};
    vecs[9]  = '{4'b0001, 1'b0, 0, 1023, 12'h7E7, 1'b1, 1024, 1'b0, 12'h7E7};
    vecs[10] = '{4'b0010, 1'b0, 1, 1022, 12'h111, 1'b1, 1023, 1'b0, 12'h111};

    rst_n          = 1'b0;
    req_valid      = 4'b0;
    req_chan       = {3'd1, 3'd7, 3'd2, 3'd5};
    spi_data_valid = 1'b0;
    spi_data       = 12'h0;
    #23;
    chk("rst_grant", 32'(req_grant), 32'd0);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_spi_chan", 32'(spi_chan), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_job(vecs[i].mask, vecs[i].hold, vecs[i].exp_id, vecs[i].lat, vecs[i].data,
              vecs[i].send, vecs[i].exp_delay, vecs[i].exp_to, vecs[i].exp_data);
    end

    // Request withdrawn before GRANT samples it.
    req_valid = 4'b0100;
    tick();
    chk("wd_busy_grant", 32'(busy), 32'd1);
    req_valid = 4'b0000;
    tick();
    chk("wd_no_grant", 32'(req_grant), 32'd0);
    chk("wd_no_start", 32'(spi_start), 32'd0);
    chk("wd_busy_low", 32'(busy), 32'd0);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);

    // Spurious data_valid in IDLE.
    spi_data_valid = 1'b1;
    spi_data = 12'hFFF;
    tick();
    spi_data_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid || busy) cnt++;
    end
    chk("spurious_ignored", cnt, 0);
    chk("spurious_data_kept", 32'(rsp_data), 32'h111);

    // Reset while a conversion is in flight.
    req_valid = 4'b0010;
    tick();
    tick();
    chk("rw_grant", 32'(req_grant), 32'b0010);
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_spi_chan", 32'(spi_chan), 32'd0);
    chk("rw_rsp_data", 32'(rsp_data), 32'd0);
    chk("rw_rsp_chan", 32'(rsp_chan), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    spi_data_valid = 1'b1;
    spi_data = 12'h9A9;
    tick();
    spi_data_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) cnt++;
    end
    chk("rw_no_rsp", cnt, 0);

    // Fairness after reset: pointer back at 0, rotation 0,1,2,3,0,1.
    s0 = n_start;
    r0 = n_rsp;
    for (int j = 0; j < 6; j++) begin
      run_job(4'b1111, 1'b1, j % 4, 20, 12'(12'h100 + j), 1'b1, 21, 1'b0, 12'(12'h100 + j));
    end
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    chk("fair_starts", n_start - s0, 6);
    chk("fair_rsps", n_rsp - r0, 6);
    chk("fair_end_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
